// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier controller.
// Optional early exit on a zero multiplier: define MULT_EARLY_EXIT_EN.
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter: cleared on LOAD, stepped once per performed shift.
// Flags the final iteration so the FSM can leave CALC.
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter  int WIDTH = MULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] iter,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iter <= '0;
        end else if (clr) begin
            iter <= '0;
        end else if (inc) begin
            iter <= iter + 1'b1;
        end
    end

    assign last = (iter == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Control FSM for a sequential 16x16 shift-and-add multiplier.
// Optional early exit on zero multiplier: define MULT_EARLY_EXIT_EN.
module mult_ctrl_fsm
    import mult_pkg::*;
#(
    parameter  int WIDTH = MULT_WIDTH,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mplier_lsb,
    input  logic             mplier_zero,
    output logic             load,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] iter
);

    mult_state_t state;
    logic        calc_q;
    logic        last;
    logic        early;

`ifdef MULT_EARLY_EXIT_EN
    assign early = calc_q & mplier_zero;
`else
    logic unused_zero;
    assign unused_zero = mplier_zero;
    assign early       = 1'b0;
`endif

    // The only Mealy outputs: a zero-exit cycle performs no step.
    assign shift_en = calc_q & ~early;
    assign add_en   = shift_en & mplier_lsb;

    mult_iter_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .inc   (shift_en),
        .iter  (iter),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            load   <= 1'b0;
            calc_q <= 1'b0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            load   <= 1'b0;
            calc_q <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        load  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    state  <= CALC;
                    calc_q <= 1'b1;
                end
                CALC: begin
                    if (last || early) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        calc_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Randomized bench for mult_ctrl_fsm with a small datapath beside it.
// Expected results come from a*b and bit-position arithmetic on b.
module tb_mult_ctrl_fsm;

`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mplier_lsb;
    logic       mplier_zero;
    logic       load;
    logic       add_en;
    logic       shift_en;
    logic       busy;
    logic       valid;
    logic [4:0] iter;

    logic [15:0] opa, opb;
    logic [31:0] dp_mc, dp_acc;
    logic [15:0] dp_mp;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mult_ctrl_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mplier_lsb  (mplier_lsb),
        .mplier_zero (mplier_zero),
        .load        (load),
        .add_en      (add_en),
        .shift_en    (shift_en),
        .busy        (busy),
        .valid       (valid),
        .iter        (iter)
    );

    always @(posedge clk) begin
        if (load) begin
            dp_mc  <= {16'h0, opa};
            dp_mp  <= opb;
            dp_acc <= '0;
        end else begin
            if (add_en) dp_acc <= dp_acc + dp_mc;
            if (shift_en) begin
                dp_mc <= dp_mc << 1;
                dp_mp <= dp_mp >> 1;
            end
        end
    end

    assign mplier_lsb  = dp_mp[0];
    assign mplier_zero = (dp_mp == 16'h0);

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        opa   = '0;
        opb   = '0;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({load, add_en, shift_en, busy, valid, iter} !== 10'h0) begin
                fails++;
                $display("FAIL reset_outs edge%0d: got l%b a%b s%b b%b v%b it%0d expected all 0",
                         e, load, add_en, shift_en, busy, valid, iter);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({load, busy, valid, iter} !== 8'h0) begin
            fails++;
            $display("FAIL reset_idle: got l%b b%b v%b it%0d expected all 0",
                     load, busy, valid, iter);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit hold, input bit poke);
        int nbits, exp_lat, exp_iter, vcyc, calc_i, bad;
        logic [31:0] prod;
        logic [4:0]  it;
        nbits = 0;
        for (int i = 0; i < 16; i++) if (b[i]) nbits = i + 1;
        exp_lat  = EARLY ? ((nbits + 3 < 18) ? nbits + 3 : 18) : 18;
        exp_iter = EARLY ? nbits : 16;
        vcyc = 0; calc_i = 0; bad = 0;
        prod = '0; it = '0;
        opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40 && vcyc == 0; k++) begin
            @(negedge clk);
            start = hold || (poke && k == 5);
            if (k == 1) begin
                checks++;
                if (load !== 1'b1) begin
                    fails++;
                    $display("FAIL load_cycle a=%h b=%h: load=%b expected 1", a, b, load);
                end
            end
            if (shift_en === 1'b1) begin
                if (calc_i >= 16 || add_en !== b[calc_i[3:0]]) bad++;
                calc_i++;
            end else if (add_en !== 1'b0) begin
                bad++;
            end
            if (load && (shift_en || valid)) bad++;
            if (valid && shift_en) bad++;
            if (busy !== 1'b1) bad++;
            if (valid === 1'b1) begin
                vcyc  = k;
                prod  = dp_acc;
                it    = iter;
                start = hold || poke;
            end
        end
        checks++;
        if (vcyc != exp_lat) begin
            fails++;
            $display("FAIL latency a=%h b=%h: got %0d expected %0d", a, b, vcyc, exp_lat);
        end
        checks++;
        if (prod !== a * b) begin
            fails++;
            $display("FAIL product a=%h b=%h: got %h expected %h", a, b, prod, 32'(a) * 32'(b));
        end
        checks++;
        if (it !== 5'(exp_iter)) begin
            fails++;
            $display("FAIL iter a=%h b=%h: got %0d expected %0d", a, b, it, exp_iter);
        end
        checks++;
        if (calc_i != exp_iter) begin
            fails++;
            $display("FAIL shifts a=%h b=%h: got %0d expected %0d", a, b, calc_i, exp_iter);
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL strobes a=%h b=%h: got %0d bad cycles expected 0", a, b, bad);
        end
        @(negedge clk);
        checks++;
        if ({load, busy, valid} !== 3'b000) begin
            fails++;
            $display("FAIL post_done a=%h b=%h: got l%b b%b v%b expected 000",
                     a, b, load, busy, valid);
        end
        start = hold;
        if (poke && !hold) begin
            @(negedge clk);
            checks++;
            if ({load, busy} !== 2'b00) begin
                fails++;
                $display("FAIL start_ignored: got l%b b%b expected 00", load, busy);
            end
        end
    endtask

    task automatic test_nominal();
        run_op(16'd16, 16'd31, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_op(16'($urandom), 16'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(16'($urandom), 16'($urandom), 1'b1, 1'b0);
        run_op(16'($urandom), 16'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            if (n[0])
                run_op(16'($urandom), 16'($urandom_range(0, 1023)), 1'b0, 1'b0);
            else
                run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic test_abort();
        bit hit;
        int vseen;
        hit = 1'b0;
        vseen = 0;
        opa = 16'($urandom);
        opb = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 30 && !hit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (shift_en === 1'b1 && iter === 5'd7) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            fails++;
            $display("FAIL abort_reach: got no CALC with iter 7 expected one");
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({load, add_en, shift_en, busy, valid, iter} !== 10'h0) begin
            fails++;
            $display("FAIL abort_idle: got l%b a%b s%b b%b v%b it%0d expected all 0",
                     load, add_en, shift_en, busy, valid, iter);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (valid !== 1'b0 || busy !== 1'b0) vseen++;
        end
        checks++;
        if (vseen != 0) begin
            fails++;
            $display("FAIL abort_novalid: got %0d active cycles expected 0", vseen);
        end
        run_op(16'd3, 16'd5, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mult_ctrl_fsm.md
Name: mult_ctrl_fsm

Overview:
Control state machine for a sequential shift-and-add 16x16 unsigned multiplier producing a 32-bit product with a valid strobe. Sits beside the multiplier datapath, which holds the multiplicand, multiplier shift register and accumulator. Sequences load, one add/shift step per multiplier bit, and completion. Contains the iteration counter; holds no operand data.

Parameters:
WIDTH, 16, operand width in bits and number of add/shift iterations.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  request a new multiplication; sampled only in IDLE
mplier_lsb  in  1  current LSB of the datapath multiplier shift register
mplier_zero  in  1  datapath multiplier register is all zero (used only with the optional feature)
load  out  1  datapath loads operands a, b and clears the accumulator
add_en  out  1  accumulator += multiplicand this cycle
shift_en  out  1  shift multiplier right / multiplicand left this cycle
busy  out  1  operation in progress (LOAD, CALC or DONE)
valid  out  1  one-cycle pulse; product on the datapath is final
iter  out  CNT_W  completed iteration count

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- States: IDLE, LOAD, CALC, DONE. Binary encoding, registered state.
- While rst_n=0 at a clk edge: state<=IDLE, iter<=0. All outputs read 0 in the following cycle.
- IDLE: all outputs 0. start=1 -> LOAD, else stay.
- LOAD: load=1, busy=1, iter<=0. Next state is unconditionally CALC.
- CALC: busy=1, shift_en=1, add_en=mplier_lsb (combinational, Mealy), iter<=iter+1. When iter==WIDTH-1 at the edge, next state is DONE; otherwise stay in CALC. This gives exactly WIDTH CALC cycles.
- DONE: valid=1, busy=1 for exactly one cycle, then IDLE. iter holds WIDTH until the next LOAD.
- Latency: start sampled at edge t gives LOAD in cycle t+1, CALC in cycles t+2..t+WIDTH+1, DONE/valid in cycle t+WIDTH+2. For WIDTH=16 that is 18 cycles after the start edge.
- start is ignored outside IDLE, including in DONE. Back-to-back operation: start held high gives LOAD directly after the IDLE cycle that follows DONE.
- load, shift_en, add_en, valid are mutually exclusive, except add_en and shift_en together in CALC.
- rst_n low mid-operation aborts to IDLE. No valid is produced for the aborted operation.
- Illegal state encodings recover to IDLE on the next edge.

Optional Feature:
MULT_EARLY_EXIT_EN:
- Defined: in CALC, if mplier_zero=1 the FSM goes to DONE at that edge, with add_en=0 and shift_en=0 in that cycle. iter reports the iterations actually performed. Latency becomes data-dependent, minimum 3 cycles (start edge -> valid).
- Not defined: mplier_zero is ignored and every operation takes exactly WIDTH CALC cycles.

Decomposition:
- Package mult_pkg: state typedef (IDLE, LOAD, CALC, DONE), default WIDTH, CNT_W derivation.
- Sub-module mult_iter_cnt: counter with clear (LOAD), increment (CALC) and terminal flag iter==WIDTH-1. The FSM instantiates it.

Test Plan:
- Reset: rst_n=0 for 2 edges with start=1 -> state IDLE, all outputs 0, iter=0; no LOAD while rst_n=0.
- Nominal a=16, b=31: start pulse, bench datapath model supplies mplier_lsb from b -> 1 load cycle, 16 shift_en cycles, add_en in the first 5 CALC cycles only, valid exactly 18 cycles after the start edge, product 496, iter=16.
- b=0xFFFF, a=0xFFFF -> add_en in all 16 CALC cycles, product 0xFFFE0001, single valid pulse.
- start re-asserted during CALC and during DONE -> ignored; next LOAD only after IDLE is reached.
- rst_n=0 at CALC iteration 7 -> IDLE next cycle, no valid; a subsequent start with a=3, b=5 gives product 15 with normal 18-cycle latency.
- With MULT_EARLY_EXIT_EN, a=16, b=31 -> DONE after 5 shifts (mplier_zero=1), iter=5, valid 8 cycles after start, product 496. Without the macro -> still 18 cycles.
